// File: rtl/oc8051_pc_tracker.sv
// Commit-stream tracker for the 8051 core: logs the last two committed PCs,
// classifies each PC change and flags a stalled pipeline via a watchdog.
//
// state | meaning
// IDLE  | no commit seen since reset
// RUN   | commits flowing, watchdog counting idle cycles
// STALL | watchdog expired, waiting for the next commit
module oc8051_pc_tracker #(
  parameter int unsigned STALL_MAX = 255,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_i,
  input  logic [15:0]      pc_i,
  input  logic [1:0]       len_i,
  input  logic             int_ack_i,
  output logic [15:0]      pc_log,
  output logic [15:0]      pc_log_prev,
  output logic             pc_log_change,
  output logic             seq_o,
  output logic             branch_o,
  output logic             irq_entry_o,
  output logic             first_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [15:0]      WD_MAX  = 16'(STALL_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t           state, state_nxt;
  logic [1:0]       len_q, len_nxt;
  logic [15:0]      wd_cnt, wd_nxt, wd_inc;
  logic             irq_pend, irq_nxt;
  logic [15:0]      pc_log_nxt, pc_log_prev_nxt;
  logic             change_nxt, seq_nxt, branch_nxt, irq_entry_nxt;
  logic             first_nxt, stall_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             seq_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc_log        <= 16'h0000;
      pc_log_prev   <= 16'h0000;
      len_q         <= 2'd1;
      wd_cnt        <= 16'h0000;
      irq_pend      <= 1'b0;
      instr_cnt     <= '0;
      pc_log_change <= 1'b0;
      seq_o         <= 1'b0;
      branch_o      <= 1'b0;
      irq_entry_o   <= 1'b0;
      first_o       <= 1'b1;
      stall_o       <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc_log        <= pc_log_nxt;
      pc_log_prev   <= pc_log_prev_nxt;
      len_q         <= len_nxt;
      wd_cnt        <= wd_nxt;
      irq_pend      <= irq_nxt;
      instr_cnt     <= cnt_nxt;
      pc_log_change <= change_nxt;
      seq_o         <= seq_nxt;
      branch_o      <= branch_nxt;
      irq_entry_o   <= irq_entry_nxt;
      first_o       <= first_nxt;
      stall_o       <= stall_nxt;
    end
  end

  // len_q is stored already normalised (0 -> 1), so the sum is the fall-through PC
  assign seq_hit = (pc_i == (pc_log + 16'(len_q)));
  assign wd_inc  = (wd_cnt >= WD_MAX) ? WD_MAX : (wd_cnt + 16'd1);

  always_comb begin
    state_nxt       = state;
    pc_log_nxt      = pc_log;
    pc_log_prev_nxt = pc_log_prev;
    len_nxt         = len_q;
    wd_nxt          = wd_cnt;
    irq_nxt         = irq_pend | int_ack_i;
    cnt_nxt         = instr_cnt;
    change_nxt      = 1'b0;
    seq_nxt         = 1'b0;
    branch_nxt      = 1'b0;
    irq_entry_nxt   = 1'b0;
    first_nxt       = first_o;
    stall_nxt       = stall_o;

    if (commit_i) begin
      // an ack coinciding with this commit belongs to the next one
      irq_nxt    = int_ack_i;
      cnt_nxt    = (instr_cnt == CNT_MAX) ? instr_cnt : (instr_cnt + CNT_ONE);
      wd_nxt     = 16'h0000;
      len_nxt    = (len_i == 2'd0) ? 2'd1 : len_i;
      pc_log_nxt = pc_i;
      first_nxt  = 1'b0;
      stall_nxt  = 1'b0;
    end

    case (state)
      IDLE: begin
        if (commit_i) begin
          pc_log_prev_nxt = pc_i;
          state_nxt       = RUN;
        end
      end
      RUN, STALL: begin
        if (commit_i) begin
          pc_log_prev_nxt = pc_log;
          state_nxt       = RUN;
          if (pc_i != pc_log) begin
            change_nxt    = 1'b1;
            seq_nxt       = seq_hit;
            irq_entry_nxt = irq_pend;
            branch_nxt    = !seq_hit && !irq_pend;
          end
        end else begin
          wd_nxt = wd_inc;
          if (wd_inc == WD_MAX) begin
            state_nxt = STALL;
            stall_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/oc8051_pc_tracker.md
OC8051_PC_TRACKER -- requirements
Module: oc8051_pc_tracker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter STALL_MAX, default 255, SHALL set the watchdog limit in cycles without a commit (range 1..65535).
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the commit counter.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 commit_i  input  1  one-cycle strobe: the core completed an instruction.
REQ-007 pc_i  input  16  PC of the committed instruction; valid when commit_i=1.
REQ-008 len_i  input  2  byte length (1..3) of the committed instruction; valid when commit_i=1.
REQ-009 int_ack_i  input  1  interrupt acknowledge pulse from the core.
REQ-010 pc_log  output  16  PC of the most recent commit.
REQ-011 pc_log_prev  output  16  PC of the commit before pc_log.
REQ-012 pc_log_change  output  1  one-cycle pulse: pc_log was just updated to a different value.
REQ-013 seq_o  output  1  qualifies pc_log_change: the new PC equals the old PC plus the old length.
REQ-014 branch_o  output  1  qualifies pc_log_change: non-sequential and not an interrupt entry.
REQ-015 irq_entry_o  output  1  qualifies pc_log_change: the first commit after int_ack_i.
REQ-016 first_o  output  1  high from reset until the first commit.
REQ-017 stall_o  output  1  watchdog flag.
REQ-018 instr_cnt  output  CNT_W  saturating count of commits.

Function
REQ-019 The FSM SHALL have three states: IDLE (after reset), RUN and STALL; all outputs SHALL be registered.
REQ-020 IDLE + commit_i: pc_log and pc_log_prev SHALL load pc_i, len_q SHALL load len_i, pc_log_change SHALL stay 0, first_o SHALL fall and the FSM SHALL enter RUN.
REQ-021 RUN/STALL + commit_i: pc_log_prev SHALL load pc_log, pc_log SHALL load pc_i and len_q SHALL load len_i, all on the next edge.
REQ-022 pc_log_change SHALL be 1 for exactly the cycle after a RUN/STALL commit where pc_i != old pc_log, and 0 otherwise.
REQ-023 On a change, seq_o SHALL equal (pc_i == old pc_log + len_q) using 16-bit modulo arithmetic, so 0xFFFF+1 wraps to 0x0000.
REQ-024 On a change, irq_entry_o SHALL equal the irq-pending flag, and branch_o SHALL equal !seq_o && !irq_entry_o.
REQ-025 seq_o, branch_o and irq_entry_o SHALL be 0 whenever pc_log_change is 0.
REQ-026 A commit with pc_i equal to the old pc_log SHALL still shift pc_log_prev, increment the counter and restart the watchdog, but SHALL NOT pulse pc_log_change.
REQ-027 int_ack_i SHALL set the irq-pending flag; the next commit SHALL consume it.
REQ-028 If int_ack_i and commit_i occur in the same cycle, the flag SHALL apply to the following commit, not the current one.
REQ-029 instr_cnt SHALL increment on every commit, including the IDLE commit, and SHALL hold at 2^CNT_W-1 without wrapping.
REQ-030 The watchdog counter SHALL increment each RUN/STALL cycle without a commit, clear on any commit, and saturate at STALL_MAX.
REQ-031 In RUN, when the watchdog counter reaches STALL_MAX with no commit, the next state SHALL be STALL and stall_o SHALL be 1.
REQ-032 In STALL, a commit SHALL return the FSM to RUN and clear stall_o the next cycle, and that commit SHALL be processed normally.
REQ-033 If a commit arrives in the cycle the watchdog would expire, the commit SHALL win: no STALL entry.
REQ-034 The watchdog SHALL be inactive in IDLE, so stall_o is never set before the first commit.
REQ-035 len_i values 0 and 1 SHALL both be treated as length 1 in the sequential check.

Reset
REQ-036 rst SHALL force all state immediately, independent of clk: FSM=IDLE, pc_log=0, pc_log_prev=0, len_q=1, instr_cnt=0, watchdog=0, irq flag=0.
REQ-037 While rst is high, outputs SHALL read: pc_log_change=0, seq_o=0, branch_o=0, irq_entry_o=0, stall_o=0, first_o=1.
REQ-038 rst asserted mid-operation, including in STALL or with irq pending, SHALL discard all history.
REQ-039 The first commit after rst deasserts SHALL behave per REQ-020.

Verification
REQ-040 Reset, then commits at PC 0x0000 (len 2), 0x0002 (len 1), 0x0003 -> first_o falls after the first commit; two change pulses follow, both with seq_o=1; instr_cnt=3.
REQ-041 Commit 0x0010 (len 3), then 0x0200 -> change with branch_o=1 and pc_log_prev=0x0010; then int_ack_i followed by commit 0x0003 -> irq_entry_o=1 and branch_o=0.
REQ-042 Commit 0xFFFF (len 1), then 0x0000 -> seq_o=1 (wrap-around); a repeated commit of 0x0000 -> no pulse, but instr_cnt increments.
REQ-043 STALL_MAX=4: no commit for 4 cycles after RUN entry -> stall_o=1; the next commit clears it one cycle later; a commit arriving on cycle 4 -> stall_o stays 0.
REQ-044 CNT_W=3 with 9 commits -> instr_cnt holds at 7.
REQ-045 Assert rst asynchronously while in STALL with irq pending -> all outputs reach reset values before the next clk edge; the first commit afterwards gives no change pulse.
